branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_resolve_unit.sv | 176 +++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolver: decodes MIPS-style branches, jumps and TEQ traps, registers the outcome one cycle later.
// Optional 2-bit saturating predictor table is built when BRU_PREDICT_EN is defined.
module branch_resolve_unit #(
  parameter int WIDTH     = 32,
  parameter int PHT_IDX_W = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 stall,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [5:0]           op,
  input  logic [5:0]           func,
  input  logic [4:0]           rt,
  input  logic [PHT_IDX_W-1:0] pc_idx,
  input  logic                 pred_taken,
  input  logic                 exception,
  input  logic                 exc_ack,
  input  logic [PHT_IDX_W-1:0] if_idx,
  output logic                 if_pred,
  output logic                 res_valid,
  output logic                 branch,
  output logic                 mispredict,
  output logic                 exc_pending,
  output logic [CNT_W-1:0]     br_cnt,
  output logic [CNT_W-1:0]     mp_cnt
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;
  localparam logic [5:0] FN_TEQ     = 6'b110100;

  typedef enum logic {ST_RUN, ST_EXC} state_e;

  state_e           state_q, state_d;
  logic             res_valid_q, res_valid_d;
  logic             branch_q, branch_d;
  logic             mispredict_q, mispredict_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;

  logic accept, trap_req, pht_we;
  logic is_cond, is_uncond, is_teq, taken, a_neg, a_zero;

  // Handshake: an ID instruction is taken when in_valid && !stall && !exc_pending;
  // stall is the only back-pressure and freezes every register except under rst.
  assign accept = in_valid & ~stall & (state_q == ST_RUN);
  assign a_neg  = a[WIDTH-1];
  assign a_zero = (a == '0);

  always_comb begin
    is_cond   = 1'b0;
    is_uncond = 1'b0;
    is_teq    = 1'b0;
    taken     = 1'b0;
    case (op)
      OP_BEQ:  begin is_cond = 1'b1; taken = (a == b); end
      OP_BNE:  begin is_cond = 1'b1; taken = (a != b); end
      OP_BLEZ: begin is_cond = 1'b1; taken = a_neg | a_zero; end
      OP_BGTZ: begin is_cond = 1'b1; taken = ~a_neg & ~a_zero; end
      OP_REGIMM: begin
        if (rt == 5'b00001) begin
          is_cond = 1'b1;
          taken   = ~a_neg;
        end else if (rt == 5'b00000) begin
          is_cond = 1'b1;
          taken   = a_neg;
        end
      end
      OP_J, OP_JAL: is_uncond = 1'b1;
      OP_SPECIAL: begin
        is_uncond = (func == FN_JR) | (func == FN_JALR);
        is_teq    = (func == FN_TEQ);
      end
      default: ;
    endcase
  end

  assign trap_req = exception | (accept & is_teq & (a == b));

  always_comb begin
    state_d      = state_q;
    res_valid_d  = res_valid_q;
    branch_d     = branch_q;
    mispredict_d = mispredict_q;
    br_cnt_d     = br_cnt_q;
    mp_cnt_d     = mp_cnt_q;
    pht_we       = 1'b0;
    if (!stall) begin
      res_valid_d  = 1'b0;
      branch_d     = 1'b0;
      mispredict_d = 1'b0;
      case (state_q)
        ST_RUN: begin
          if (trap_req) begin
            // A trap overrides whatever branch outcome was decoded.
            state_d     = ST_EXC;
            res_valid_d = 1'b1;
            branch_d    = 1'b1;
          end else if (accept) begin
            res_valid_d = 1'b1;
            if (is_cond) begin
              branch_d     = taken;
              mispredict_d = taken ^ pred_taken;
              pht_we       = 1'b1;
              if (br_cnt_q != '1) br_cnt_d = br_cnt_q + CNT_W'(1);
              if ((taken ^ pred_taken) && (mp_cnt_q != '1)) mp_cnt_d = mp_cnt_q + CNT_W'(1);
            end else if (is_uncond) begin
              branch_d = 1'b1;
            end
          end
        end
        ST_EXC: begin
          if (exc_ack && !exception) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      res_valid_q  <= 1'b0;
      branch_q     <= 1'b0;
      mispredict_q <= 1'b0;
      br_cnt_q     <= '0;
      mp_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      res_valid_q  <= res_valid_d;
      branch_q     <= branch_d;
      mispredict_q <= mispredict_d;
      br_cnt_q     <= br_cnt_d;
      mp_cnt_q     <= mp_cnt_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign branch      = branch_q;
  assign mispredict  = mispredict_q;
  assign exc_pending = (state_q == ST_EXC);
  assign br_cnt      = br_cnt_q;
  assign mp_cnt      = mp_cnt_q;

`ifdef BRU_PREDICT_EN
  logic [1:0] pht_q [1 << PHT_IDX_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < (1 << PHT_IDX_W); i++) pht_q[i] <= 2'b01;
    end else if (pht_we) begin
      if (taken && (pht_q[pc_idx] != 2'b11)) pht_q[pc_idx] <= pht_q[pc_idx] + 2'd1;
      else if (!taken && (pht_q[pc_idx] != 2'b00)) pht_q[pc_idx] <= pht_q[pc_idx] - 2'd1;
    end
  end

  // Registered table read: a same-cycle update is seen only from the next cycle.
  assign if_pred = pht_q[if_idx][1];
`else
  logic unused_pred_inputs;
  assign unused_pred_inputs = ^{pht_we, pc_idx, if_idx};
  assign if_pred = 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized bench for branch_resolve_unit: a per-cycle reference model feeds expected-value queues drained by a monitor.
module tb_branch_resolve_unit;

  localparam int OUT_W = 36;

`ifdef BRU_PREDICT_EN
  localparam bit PRED_EN = 1'b1;
`else
  localparam bit PRED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, stall = 1'b0, pred_taken = 1'b0;
  logic        exception = 1'b0, exc_ack = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [5:0]  op = '0, func = '0;
  logic [4:0]  rt = '0;
  logic [3:0]  pc_idx = '0, if_idx = '0;
  logic        if_pred, res_valid, branch, mispredict, exc_pending;
  logic [15:0] br_cnt, mp_cnt;

  branch_resolve_unit #(.WIDTH(32), .PHT_IDX_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall),
    .a(a), .b(b), .op(op), .func(func), .rt(rt),
    .pc_idx(pc_idx), .pred_taken(pred_taken), .exception(exception),
    .exc_ack(exc_ack), .if_idx(if_idx), .if_pred(if_pred),
    .res_valid(res_valid), .branch(branch), .mispredict(mispredict),
    .exc_pending(exc_pending), .br_cnt(br_cnt), .mp_cnt(mp_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus record ----------------
  typedef struct {
    logic        rst, stall, iv, pt, ex, ack;
    logic [5:0]  op, func;
    logic [4:0]  rt;
    logic [31:0] a, b;
    logic [3:0]  pidx, iidx;
  } stim_t;

  // ---------------- reference model ----------------
  logic m_rv = 0, m_br = 0, m_mp = 0, m_pend = 0;
  int   m_brc = 0, m_mpc = 0;
  int   m_pht[16];

  // kind: 0 none, 1 conditional, 2 jump, 3 TEQ
  function automatic int classify(input stim_t s, output bit tk);
    longint sa;
    sa = longint'($signed(s.a));
    tk = 1'b0;
    case (s.op)
      6'd4: begin tk = (s.a == s.b); return 1; end
      6'd5: begin tk = (s.a != s.b); return 1; end
      6'd6: begin tk = (sa <= 0); return 1; end
      6'd7: begin tk = (sa > 0); return 1; end
      6'd1: begin
        if (s.rt == 5'd1) begin tk = (sa >= 0); return 1; end
        if (s.rt == 5'd0) begin tk = (sa < 0); return 1; end
        return 0;
      end
      6'd2, 6'd3: return 2;
      6'd0: begin
        if (s.func == 6'd8 || s.func == 6'd9) return 2;
        if (s.func == 6'd52) return 3;
        return 0;
      end
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input stim_t s);
    int kind;
    bit tk;
    kind = classify(s, tk);
    if (s.rst) begin
      m_rv = 0; m_br = 0; m_mp = 0; m_pend = 0; m_brc = 0; m_mpc = 0;
      for (int i = 0; i < 16; i++) m_pht[i] = 1;
    end else if (s.stall) begin
      // everything frozen
    end else if (m_pend) begin
      m_rv = 0; m_br = 0; m_mp = 0;
      m_pend = s.ex || !s.ack;
    end else if (s.ex || (s.iv && kind == 3 && s.a == s.b)) begin
      m_pend = 1; m_rv = 1; m_br = 1; m_mp = 0;
    end else if (s.iv) begin
      m_rv = 1; m_br = (kind == 2) || (kind == 1 && tk); m_mp = 0;
      if (kind == 1) begin
        m_mp = (tk != s.pt);
        if (m_brc < 65535) m_brc++;
        if (m_mp && m_mpc < 65535) m_mpc++;
        if (tk) m_pht[s.pidx] = (m_pht[s.pidx] < 3) ? m_pht[s.pidx] + 1 : 3;
        else    m_pht[s.pidx] = (m_pht[s.pidx] > 0) ? m_pht[s.pidx] - 1 : 0;
      end
    end else begin
      m_rv = 0; m_br = 0; m_mp = 0;
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [OUT_W-1:0] exp_q[$];
  int               exp_due_q[$];
  logic             pred_q[$];
  int               pred_due_q[$];
  int n_cmp = 0, n_err = 0;

  always @(negedge clk) begin
    while (exp_due_q.size() > 0 && exp_due_q[0] <= cyc) begin
      int due;
      logic [OUT_W-1:0] e, g;
      due = exp_due_q.pop_front();
      e = exp_q.pop_front();
      g = {res_valid, branch, mispredict, exc_pending, br_cnt, mp_cnt};
      n_cmp++;
      if (due != cyc || g !== e) begin
        n_err++;
        $display("FAIL outputs cyc=%0d due=%0d got rv/br/mp/pend=%b%b%b%b brc=%0d mpc=%0d required rv/br/mp/pend=%b%b%b%b brc=%0d mpc=%0d",
                 cyc, due, g[35], g[34], g[33], g[32], g[31:16], g[15:0],
                 e[35], e[34], e[33], e[32], e[31:16], e[15:0]);
      end
    end
    while (pred_due_q.size() > 0 && pred_due_q[0] <= cyc) begin
      int due;
      logic e;
      due = pred_due_q.pop_front();
      e = pred_q.pop_front();
      n_cmp++;
      if (due != cyc || if_pred !== e) begin
        n_err++;
        $display("FAIL if_pred cyc=%0d idx=%0d got=%b required=%b", cyc, if_idx, if_pred, e);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input stim_t s);
    @(posedge clk);
    #1;
    rst = s.rst; stall = s.stall; in_valid = s.iv; pred_taken = s.pt;
    exception = s.ex; exc_ack = s.ack; op = s.op; func = s.func; rt = s.rt;
    a = s.a; b = s.b; pc_idx = s.pidx; if_idx = s.iidx;
    pred_q.push_back(PRED_EN ? (m_pht[s.iidx] >= 2) : 1'b0);
    pred_due_q.push_back(cyc);
    model_step(s);
    exp_q.push_back({m_rv, m_br, m_mp, m_pend, 16'(m_brc), 16'(m_mpc)});
    exp_due_q.push_back(cyc + 1);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 0, stall: 0, iv: 0, pt: 0, ex: 0, ack: 0, op: 6'h23, func: 0,
          rt: 5'd2, a: 0, b: 0, pidx: 0, iidx: 0};
    return s;
  endfunction

  function automatic stim_t instr(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r,
                                  input logic [31:0] va, input logic [31:0] vb, input logic p);
    stim_t s;
    s = idle();
    s.iv = 1; s.op = o; s.func = f; s.rt = r; s.a = va; s.b = vb; s.pt = p;
    return s;
  endfunction

  logic [5:0]  op_tab[9]  = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'h23};
  logic [5:0]  fn_tab[4]  = '{6'd8, 6'd9, 6'd52, 6'd32};
  logic [31:0] val_tab[7] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'd5, 32'd7, 32'h8000_0000, 32'h7FFF_FFFF};

  function automatic logic [31:0] rand_val();
    if ($urandom_range(3) == 0) return $urandom;
    return val_tab[$urandom_range(6)];
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s = idle();
    s.rst   = ($urandom_range(99) == 0);
    s.stall = ($urandom_range(4) == 0);
    s.iv    = ($urandom_range(3) != 0);
    s.op    = op_tab[$urandom_range(8)];
    s.func  = fn_tab[$urandom_range(3)];
    s.rt    = 5'($urandom_range(2));
    s.a     = rand_val();
    s.b     = ($urandom_range(2) == 0) ? s.a : rand_val();
    s.pidx  = 4'($urandom_range(15));
    s.iidx  = 4'($urandom_range(15));
    s.pt    = 1'($urandom_range(1));
    s.ex    = ($urandom_range(19) == 0);
    s.ack   = ($urandom_range(2) == 0);
    return s;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    stim_t s;
    for (int i = 0; i < 16; i++) m_pht[i] = 1;

    s = idle(); s.rst = 1; drive(s);
    drive(idle());

    // BEQ equal, predicted not-taken
    drive(instr(6'd4, 6'd0, 5'd0, 32'd5, 32'd5, 1'b0));
    // BGEZ / BLTZ with a = -1
    drive(instr(6'd1, 6'd0, 5'd1, 32'hFFFF_FFFF, 32'd0, 1'b0));
    drive(instr(6'd1, 6'd0, 5'd0, 32'hFFFF_FFFF, 32'd0, 1'b0));

    // predictor training at index 3
    for (int i = 0; i < 4; i++) begin
      s = instr(6'd5, 6'd0, 5'd0, 32'd1, 32'd2, 1'b1); s.pidx = 3; s.iidx = 3; drive(s);
    end
    s = instr(6'd5, 6'd0, 5'd0, 32'd9, 32'd9, 1'b1); s.pidx = 3; s.iidx = 3; drive(s);
    s = idle(); s.iidx = 3; drive(s);

    // TEQ trap, ignored BEQ, acknowledge, external exception, exception+ack overlap
    drive(instr(6'd0, 6'd52, 5'd0, 32'd7, 32'd7, 1'b0));
    drive(instr(6'd4, 6'd0, 5'd0, 32'd1, 32'd1, 1'b0));
    drive(idle());
    s = idle(); s.ack = 1; drive(s);
    drive(instr(6'd0, 6'd52, 5'd0, 32'd7, 32'd8, 1'b0));
    s = idle(); s.ex = 1; drive(s);
    s = idle(); s.ex = 1; s.ack = 1; drive(s);
    drive(idle());
    s = idle(); s.ack = 1; drive(s);
    s = idle(); s.ex = 1; s.ack = 1; drive(s);
    s = idle(); s.ack = 1; drive(s);

    // JR held by stall, then released; then rst during stall
    for (int i = 0; i < 3; i++) begin
      s = instr(6'd0, 6'd8, 5'd0, 32'd0, 32'd0, 1'b0); s.stall = 1; drive(s);
    end
    drive(instr(6'd0, 6'd8, 5'd0, 32'd0, 32'd0, 1'b0));
    s = instr(6'd0, 6'd8, 5'd0, 32'd0, 32'd0, 1'b0); s.stall = 1; drive(s);
    s = idle(); s.stall = 1; s.rst = 1; drive(s);
    drive(idle());

    for (int i = 0; i < 800; i++) drive(rand_stim());

    drive(idle());
    drive(idle());
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0 || pred_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got=%0d/%0d pending entries required=0/0", exp_q.size(), pred_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
